// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALUOp/funct decoder with a registered ALU control code and multi-cycle MULT/DIV sequencing.
// Optional ALU_CTRL_ILLEGAL_EN raises illegal_o for undecodable ops and for nonzero upper input bits.
module alu_ctrl_seq #(
    parameter int FUNCT_W    = 6,
    parameter int ALUOP_W    = 3,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [ALUOP_W-1:0] ALUOp_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [CTRL_W-1:0]  ALUCtrl_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               illegal_o
);
    typedef enum logic {IDLE, MULTI} state_t;
    localparam logic [7:0] MUL_N = 8'(MUL_CYCLES);
    localparam logic [7:0] DIV_N = 8'(DIV_CYCLES);
    state_t state, state_d;
    logic [7:0] cnt, cnt_d, n;
    logic [CTRL_W-1:0] ctrl_d;
    logic [3:0] code;
    logic is_mul, is_div, is_ill, is_multi, accept;
    logic valid_q, valid_d, ill_q, ill_d;
    always_comb begin
        code = 4'hF;
        case (ALUOp_i[2:0])
            3'b000: case (funct_i[5:0])
                6'b100100: code = 4'h0;
                6'b100101: code = 4'h1;
                6'b100000: code = 4'h2;
                6'b100010: code = 4'h6;
                6'b101010: code = 4'h7;
                6'b100111: code = 4'hC;
                6'b000000: code = 4'h8;
                6'b000010: code = 4'h9;
                6'b011000: code = 4'hA;
                6'b011010: code = 4'hB;
                default:   code = 4'hF;
            endcase
            3'b001:  code = 4'h2;
            3'b010:  code = 4'h6;
            3'b011:  code = 4'h7;
            3'b100:  code = 4'h0;
            3'b101:  code = 4'h1;
            3'b110:  code = 4'hD;
            default: code = 4'hF;
        endcase
`ifdef ALU_CTRL_ILLEGAL_EN
        if ((|(funct_i >> 6)) || (|(ALUOp_i >> 3)))
            code = 4'hF;
`endif
    end
    assign is_mul   = code == 4'hA;
    assign is_div   = code == 4'hB;
`ifdef ALU_CTRL_ILLEGAL_EN
    assign is_ill   = code == 4'hF;
`else
    assign is_ill   = 1'b0;
`endif
    assign n        = is_mul ? MUL_N : DIV_N;
    assign is_multi = (is_mul || is_div) && n != 8'd1;
    assign busy_o   = state == MULTI && cnt != 8'd0;
    assign accept   = valid_i && !busy_o;
    // Completion pulse comes straight from MULTI with cnt==0 so a new op can issue in that same cycle.
    assign valid_o   = valid_q || (state == MULTI && cnt == 8'd0);
    assign illegal_o = ill_q;
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ctrl_d  = ALUCtrl_o;
        valid_d = 1'b0;
        ill_d   = 1'b0;
        if (state == MULTI) begin
            cnt_d   = busy_o ? cnt - 8'd1 : cnt;
            state_d = busy_o ? MULTI : IDLE;
        end
        if (accept) begin
            ctrl_d  = code == 4'hF ? '1 : CTRL_W'(code);
            cnt_d   = (is_mul || is_div) ? n - 8'd1 : 8'd0;
            state_d = is_multi ? MULTI : IDLE;
            valid_d = !is_multi;
            ill_d   = is_ill;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            ALUCtrl_o <= '1;
            valid_q   <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ALUCtrl_o <= ctrl_d;
            valid_q   <= valid_d;
            ill_q     <= ill_d;
        end
    end
endmodule
